mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sequences the MEM-stage data-memory access driven by the EXE/MEM pipeline register's MemRead/MemWrite/MemWrite64 controls onto a single 32-bit request/acknowledge memory port.
- Splits 64-bit stores into two 32-bit beats, low word first.
- Stalls the upstream pipeline (IF/ID/EXE and the EXE/MEM register) until the access completes.
- Flags illegal, misaligned or timed-out accesses.

Parameters:
- WAIT_LIMIT, 16, maximum cycles a single beat waits for mem_ack before it is aborted with Mem_err (must be >= 2).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- MemRead  input  1  32-bit load requested (from EXE/MEM).
- MemWrite  input  1  32-bit store requested.
- MemWrite64  input  1  64-bit store requested.
- Adrs_MEM  input  32  byte address.
- Rt_data_MEM  input  32  store data for 32-bit store.
- Rt_data64_MEM  input  64  store data for 64-bit store.
- mem_req  output  1  memory request (registered).
- mem_we  output  1  1 = write beat, 0 = read beat (registered).
- mem_addr  output  32  beat address (registered).
- mem_wdata  output  32  beat write data (registered).
- mem_rdata  input  32  read data, valid when mem_req && mem_ack.
- mem_ack  input  1  beat accepted/completed this cycle.
- Stall  output  1  freeze upstream stages and EXE/MEM (combinational from state/inputs).
- Rd_data_MEM  output  32  last loaded word (registered).
- Op_done  output  1  one-cycle pulse: access finished, pipeline advances this cycle.
- Mem_err  output  1  valid with Op_done: access was illegal, misaligned or timed out.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - State forced to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, Rd_data_MEM, Op_done, Mem_err and the wait counter all clear to 0.
  - Stall reads 0 while reset is held with no op present; asserting reset mid-access drops mem_req immediately and abandons the access.
- States: IDLE, RD, WR, WR_LO, WR_HI, COMPLETE.
- op_present = MemRead | MemWrite | MemWrite64.
- Stall = (IDLE && op_present) || state in {RD, WR, WR_LO, WR_HI}. Stall is 0 in COMPLETE, so the EXE/MEM register loads the next instruction at the end of the COMPLETE cycle.
- IDLE, no op: remain in IDLE; mem_req=0.
- IDLE, op_present, decode in this priority order:
  - More than one control bit set -> COMPLETE with err flag; no memory access.
  - MemRead and Adrs_MEM[1:0]!=0 -> COMPLETE with err flag; no access.
  - MemWrite and Adrs_MEM[1:0]!=0 -> COMPLETE with err flag; no access.
  - MemWrite64 and Adrs_MEM[2:0]!=0 -> COMPLETE with err flag; no access.
  - Legal MemRead -> RD; load mem_req=1, mem_we=0, mem_addr=Adrs_MEM.
  - Legal MemWrite -> WR; load mem_req=1, mem_we=1, mem_addr=Adrs_MEM, mem_wdata=Rt_data_MEM.
  - Legal MemWrite64 -> WR_LO; load mem_req=1, mem_we=1, mem_addr=Adrs_MEM, mem_wdata=Rt_data64_MEM[31:0].
- Beat states (RD/WR/WR_LO/WR_HI):
  - A beat completes in any cycle with mem_ack=1; a same-cycle ack (the first cycle of the state) is legal.
  - mem_addr, mem_we and mem_wdata are held stable until ack.
- Beat completion:
  - RD ack: Rd_data_MEM <= mem_rdata; mem_req<=0; -> COMPLETE.
  - WR ack: mem_req<=0; -> COMPLETE.
  - WR_LO ack: mem_addr<=mem_addr+4 (32-bit wrap); mem_wdata<=Rt_data64_MEM[63:32]; mem_req stays 1; -> WR_HI.
  - WR_HI ack: mem_req<=0; -> COMPLETE.
- Timeout:
  - The wait counter clears on entry to each beat state and increments each cycle without ack.
  - If the counter == WAIT_LIMIT-1 and mem_ack=0: mem_req<=0; -> COMPLETE with err flag.
  - If WR_LO times out, no high beat is issued.
- COMPLETE (exactly one cycle):
  - Op_done=1; Mem_err=err flag; Stall=0; -> IDLE unconditionally.
  - IDLE then evaluates the newly loaded EXE/MEM controls, so back-to-back accesses each pay the IDLE cycle.
- Op_done and Mem_err are 0 in every state other than COMPLETE.
- Rd_data_MEM changes only on a RD ack or reset.
- Latency with zero-wait memory (ack in first beat cycle), counting Stall cycles:
  - read or 32-bit write: 2;
  - 64-bit write: 3;
  - error detected in IDLE: 1.
- A late mem_ack arriving outside a beat state is ignored.

Test Plan:
- Load: MemRead=1, Adrs_MEM=0x100, ack 2 cycles after mem_req rises with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; Stall high 3 cycles; Rd_data_MEM=0xDEADBEEF; Op_done pulse; Mem_err=0.
- 64-bit store: MemWrite64=1, Adrs_MEM=0x208, Rt_data64_MEM=0x11223344_55667788, ack immediate -> beats (0x208, 0x55667788) then (0x20C, 0x11223344); Stall 3 cycles; Op_done=1; Mem_err=0.
- Misaligned and illegal: MemWrite=1, Adrs_MEM=0x102 -> no mem_req; Stall 1 cycle; Op_done=1 with Mem_err=1. Repeat with MemRead=MemWrite=1 -> same response.
- Timeout: MemWrite=1, Adrs_MEM=0x40, mem_ack held 0 -> mem_req drops after 16 cycles in WR; Op_done=1 with Mem_err=1; back to IDLE.
- Reset mid-access: MemWrite64 at 0x0, assert Rst_n=0 during WR_HI -> mem_req=0 immediately; all outputs 0; after release with no op, Stall=0 and state IDLE.
- Back-to-back: store 0x10 then load 0x10, zero-wait memory -> second access begins in the cycle after COMPLETE; Op_done pulses twice, 3 cycles apart.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage data-memory access sequencer
// Drives one 32-bit req/ack port from the EXE/MEM controls, splitting 64-bit stores into two beats.
module mem_access_sequencer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemWrite64,
  input  logic [31:0] Adrs_MEM,
  input  logic [31:0] Rt_data_MEM,
  input  logic [63:0] Rt_data64_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        Stall,
  output logic [31:0] Rd_data_MEM,
  output logic        Op_done,
  output logic        Mem_err
);

  localparam int CW = $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR, WR_LO, WR_HI, COMPLETE
  } state_t;

  state_t        state, state_n;
  logic          req_n, we_n, err_flag, err_n;
  logic [31:0]   addr_n, wdata_n, rd_n;
  logic [CW-1:0] wait_cnt, cnt_n;
  logic          op_present, multi_op, beat_state;

  assign op_present = MemRead | MemWrite | MemWrite64;
  assign multi_op   = (MemRead & MemWrite) | (MemRead & MemWrite64) | (MemWrite & MemWrite64);
  assign beat_state = (state == RD) || (state == WR) || (state == WR_LO) || (state == WR_HI);

  assign Stall   = ((state == IDLE) && op_present) || beat_state;
  assign Op_done = (state == COMPLETE);
  assign Mem_err = (state == COMPLETE) && err_flag;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      Rd_data_MEM <= 32'h0;
      err_flag    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      mem_req     <= req_n;
      mem_we      <= we_n;
      mem_addr    <= addr_n;
      mem_wdata   <= wdata_n;
      Rd_data_MEM <= rd_n;
      err_flag    <= err_n;
      wait_cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    rd_n    = Rd_data_MEM;
    err_n   = err_flag;
    cnt_n   = wait_cnt;
    case (state)
      IDLE: begin
        err_n = 1'b0;
        cnt_n = '0;
        if (op_present) begin
          // Illegal or misaligned ops retire through COMPLETE without touching memory
          if (multi_op || ((MemRead || MemWrite) && (Adrs_MEM[1:0] != 2'b00)) ||
              (MemWrite64 && (Adrs_MEM[2:0] != 3'b000))) begin
            err_n   = 1'b1;
            state_n = COMPLETE;
          end else begin
            req_n  = 1'b1;
            addr_n = Adrs_MEM;
            if (MemRead) begin
              we_n    = 1'b0;
              state_n = RD;
            end else if (MemWrite) begin
              we_n    = 1'b1;
              wdata_n = Rt_data_MEM;
              state_n = WR;
            end else begin
              we_n    = 1'b1;
              wdata_n = Rt_data64_MEM[31:0];
              state_n = WR_LO;
            end
          end
        end
      end
      RD, WR, WR_LO, WR_HI: begin
        if (mem_ack) begin
          cnt_n = '0;
          if (state == WR_LO) begin
            addr_n  = mem_addr + 32'd4;
            wdata_n = Rt_data64_MEM[63:32];
            state_n = WR_HI;
          end else begin
            if (state == RD) rd_n = mem_rdata;
            req_n   = 1'b0;
            state_n = COMPLETE;
          end
        end else if (wait_cnt == CNT_LAST) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = COMPLETE;
        end else begin
          cnt_n = wait_cnt + 1'b1;
        end
      end
      COMPLETE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

  localparam int WL = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        MemRead, MemWrite, MemWrite64;
  logic [31:0] Adrs_MEM, Rt_data_MEM;
  logic [63:0] Rt_data64_MEM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        Stall, Op_done, Mem_err;
  logic [31:0] Rd_data_MEM;

  mem_access_sequencer #(.WAIT_LIMIT(WL)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWrite64(MemWrite64),
    .Adrs_MEM(Adrs_MEM), .Rt_data_MEM(Rt_data_MEM), .Rt_data64_MEM(Rt_data64_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Stall(Stall), .Rd_data_MEM(Rd_data_MEM), .Op_done(Op_done), .Mem_err(Mem_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic        r, w, w64;
    logic [31:0] a, d32;
    logic [63:0] d64;
    int          dly;
    logic        err;
    int          stall;
  } vec_t;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic [31:0] dut_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] rd_model;
  int          n_checks = 0, n_fail = 0, hold_bad = 0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] a, input logic we, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.data = d;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: outcome of one access from the decode/beat/timeout rules, as whole-op arithmetic
  task automatic model_op(input logic r, w, w64, input logic [31:0] a, d32, input logic [63:0] d64,
                          input int dly, output logic err, output int stall);
    exp_q.delete();
    err   = 1'b0;
    stall = 1;
    if (int'(r) + int'(w) + int'(w64) > 1) err = 1'b1;
    else if ((r || w) && (a % 4 != 0))     err = 1'b1;
    else if (w64 && (a % 8 != 0))          err = 1'b1;
    if (err) return;
    if (r) exp_q.push_back(mk_beat(a, 1'b0, 32'h0));
    if (w) exp_q.push_back(mk_beat(a, 1'b1, d32));
    if (w64) begin
      exp_q.push_back(mk_beat(a, 1'b1, d64[31:0]));
      exp_q.push_back(mk_beat(a + 32'd4, 1'b1, d64[63:32]));
    end
    if (dly >= WL) begin
      err   = 1'b1;
      stall = 1 + WL;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      return;
    end
    stall = 1 + exp_q.size() * (dly + 1);
    foreach (exp_q[i]) if (exp_q[i].we) ref_mem[exp_q[i].addr] = exp_q[i].data;
    if (r) rd_model = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endtask

  // Presents one op in the IDLE cycle and plays a memory that acks each beat after dly wait cycles
  task automatic do_op(input logic r, w, w64, input logic [31:0] a, d32, input logic [63:0] d64,
                       input int dly, output int stall_n, output logic err_seen, output int done_cyc);
    int bw, guard;
    bit done;
    MemRead = r; MemWrite = w; MemWrite64 = w64;
    Adrs_MEM = a; Rt_data_MEM = d32; Rt_data64_MEM = d64;
    obs_q.delete();
    stall_n = 0; err_seen = 1'b0; done = 1'b0; bw = 0; guard = 0; done_cyc = -1; hold_bad = 0;
    while (!done && guard < 80) begin
      if (mem_req) begin
        if (bw == 0) obs_q.push_back(mk_beat(mem_addr, mem_we, mem_wdata));
        else if (mk_beat(mem_addr, mem_we, mem_wdata) != obs_q[$]) hold_bad++;
        if (bw >= dly) begin
          mem_ack   = 1'b1;
          mem_rdata = dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : mem_init(mem_addr);
          if (mem_we) dut_mem[mem_addr] = mem_wdata;
          bw = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          bw++;
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        bw = 0;
      end
      #1;
      if (Stall) stall_n++;
      if (Op_done) begin
        done = 1'b1; err_seen = Mem_err; done_cyc = cyc;
        MemRead = 1'b0; MemWrite = 1'b0; MemWrite64 = 1'b0;
      end
      @(negedge Clk);
      guard++;
    end
    mem_ack = 1'b0;
    #1;
    chk("op_done_seen", done, 1'b1);
    chk("op_done_one_cycle", {Op_done, Mem_err, Stall, mem_req}, 4'b0000);
  endtask

  task automatic run_check(input string tag, input logic r, w, w64, input logic [31:0] a, d32,
                           input logic [63:0] d64, input int dly, input bit use_tab,
                           input logic t_err, input int t_stall, output int done_cyc);
    logic m_err, e_seen;
    int   m_stall, s_seen, nb;
    model_op(r, w, w64, a, d32, d64, dly, m_err, m_stall);
    do_op(r, w, w64, a, d32, d64, dly, s_seen, e_seen, done_cyc);
    chk({tag, "_err"},   e_seen, use_tab ? t_err : m_err);
    chk({tag, "_stall"}, s_seen, use_tab ? t_stall : m_stall);
    chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    nb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s_beat%0d_addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_beat%0d_we", tag, i), obs_q[i].we, exp_q[i].we);
      if (exp_q[i].we) chk($sformatf("%s_beat%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
    end
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_rd_data"}, Rd_data_MEM, rd_model);
  endtask

  vec_t vecs[12];
  int   dc[12];
  int   dcr;

  initial begin
    logic        r, w, w64;
    logic [31:0] a;
    int          kind, dly;

    vecs[0]  = '{1, 0, 0, 32'h100, 32'h0,        64'h0,                   1,  0, 3};
    vecs[1]  = '{0, 0, 1, 32'h208, 32'h0,        64'h11223344_55667788,   0,  0, 3};
    vecs[2]  = '{0, 1, 0, 32'h102, 32'h12345678, 64'h0,                   0,  1, 1};
    vecs[3]  = '{1, 1, 0, 32'h100, 32'h12345678, 64'h0,                   0,  1, 1};
    vecs[4]  = '{0, 1, 0, 32'h40,  32'h0BADF00D, 64'h0,                   20, 1, 17};
    vecs[5]  = '{0, 0, 1, 32'h204, 32'h0,        64'h01020304_05060708,   0,  1, 1};
    vecs[6]  = '{1, 0, 0, 32'h101, 32'h0,        64'h0,                   0,  1, 1};
    vecs[7]  = '{0, 1, 0, 32'h10,  32'hCAFEF00D, 64'h0,                   0,  0, 2};
    vecs[8]  = '{1, 0, 0, 32'h10,  32'h0,        64'h0,                   0,  0, 2};
    vecs[9]  = '{0, 0, 1, 32'h0,   32'h0,        64'hFEEDFACE_8BADF00D,   15, 0, 33};
    vecs[10] = '{1, 0, 0, 32'h0,   32'h0,        64'h0,                   16, 1, 17};
    vecs[11] = '{1, 1, 1, 32'h0,   32'h0,        64'h0,                   0,  1, 1};

    Rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemWrite64 = 1'b0;
    Adrs_MEM = '0; Rt_data_MEM = '0; Rt_data64_MEM = '0; mem_ack = 1'b0; mem_rdata = '0;
    dut_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    rd_model = 32'h0;

    repeat (2) @(negedge Clk);
    #1;
    chk("reset_req_we", {mem_req, mem_we}, 2'b00);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_rd_data", Rd_data_MEM, 32'h0);
    chk("reset_done_err_stall", {Op_done, Mem_err, Stall}, 3'b000);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].w64, vecs[i].a, vecs[i].d32,
                vecs[i].d64, vecs[i].dly, 1'b1, vecs[i].err, vecs[i].stall, dc[i]);
    chk("vec0_load_value", Rd_data_MEM == 32'hDEADBEEF, 1'b0);
    chk("back_to_back_spacing", dc[8] - dc[7], 3);

    // Reset asserted while the high beat of a 64-bit store is outstanding
    MemWrite64 = 1'b1; Adrs_MEM = 32'h0; Rt_data64_MEM = 64'hAAAABBBB_CCCCDDDD; mem_ack = 1'b1;
    @(negedge Clk);
    #1;
    chk("rst_lo_req", {mem_req, mem_we, mem_addr}, {2'b11, 32'h0});
    @(negedge Clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_hi_beat", {mem_req, mem_addr, mem_wdata}, {1'b1, 32'h4, 32'hAAAABBBB});
    MemWrite64 = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_regs", {mem_we, mem_addr, mem_wdata, Rd_data_MEM}, 97'h0);
    chk("rst_mid_flags", {Op_done, Mem_err, Stall}, 3'b000);
    rd_model = 32'h0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("post_rst_idle%0d", i), {Stall, mem_req, Op_done}, 3'b000);
    end
    run_check("post_rst_load", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 64'h0, 0, 1'b1, 1'b0, 2, dcr);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      r = (kind <= 3); w = (kind >= 4 && kind <= 6); w64 = (kind >= 7);
      if (kind == 9) begin r = 1'b1; w = 1'($urandom_range(0, 1)); end
      a = 32'($urandom_range(0, 7)) * 32'd8;
      if (!w64 && $urandom_range(0, 1) == 1) a = a + 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 4));
      dly = ($urandom_range(0, 9) == 0) ? WL + $urandom_range(0, 3) : $urandom_range(0, 3);
      run_check($sformatf("rnd%0d", i), r, w, w64, a, $urandom, {$urandom, $urandom}, dly,
                1'b0, 1'b0, 0, dcr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
